keypad_scanner: RTL and testbench

// - Parametrised keypad matrix scanner; successor to the fixed 4-row synckey front end.
// - Drives one-hot column strobes and samples row inputs.
// - Debounces press and release, then encodes the key to a linear index.
// - Delivers each key event through a valid/ready handshake to the request-queue logic.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_scanner_if.sv | 21 ++
 rtl/kp_stable_cnt.sv | 40 ++++
 rtl/keypad_scanner.sv | 218 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and helper functions for the keypad matrix scanner.
//            Provides the FSM state encoding, the key-code width rule and
//            the lowest-set-bit encoder used to pick a row.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } kp_state_t;

  // Width of key_code: enough for rows*cols distinct keys, never below 1.
  function automatic int kp_code_w(input int rows, input int cols);
    return (rows * cols <= 1) ? 1 : $clog2(rows * cols);
  endfunction

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic int lowest_set_idx(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int kp_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_if
// Purpose  : Key-event handshake bundle between the scanner (master) and the
//            request-queue logic (slave).
//   key_code  : encoded key index, stable while key_valid is high
//   key_valid : key_code holds an undelivered event
//   key_ready : consumer accepts when key_valid & key_ready
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface
`default_nettype wire

// File: rtl/kp_stable_cnt.sv
`default_nettype none
// ============================================================================
// Module   : kp_stable_cnt
// Purpose  : Saturating stability counter used for press and release
//            debounce. Counts cycles with match high; done flags that the
//            count has reached TERM.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count from zero
//   match    : the sampled input equals the reference this cycle
//   done     : count equals TERM (the owner qualifies it with match)
// Revision : 1.0 - initial release
// ============================================================================
module kp_stable_cnt #(
  parameter int CNT_W = 10,
  parameter int TERM  = 7
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic match,
  output logic      done
);

  localparam logic [CNT_W-1:0] c_term = CNT_W'(TERM);
  localparam logic [CNT_W-1:0] c_max  = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (match && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign done = (r_cnt == c_term);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Parametrised keypad matrix scanner. Rotates a one-hot column
//            strobe, debounces press and release, encodes the key as
//            col*ROWS + lowest active row and delivers it over valid/ready.
//   clk, rst   : clock, synchronous active-high reset
//   row        : row sense lines (active-high, already synchronised)
//   columns    : one-hot column strobe
//   kif        : key_code / key_valid / key_ready handshake (master)
//   pressed    : high from accepted press to accepted release
//   multi_key  : more than one row active at the last accepted press
//   overflow   : sticky, an event was dropped while one was pending
// Config   : define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int REPEAT_DLY   = 50000,
  parameter int REPEAT_RATE  = 10000
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [ROWS-1:0] row,
  output logic      [COLS-1:0] columns,
  keypad_scanner_if.master     kif,
  output logic                 pressed,
  output logic                 multi_key,
  output logic                 overflow
);

  localparam int c_code_w = kp_code_w(ROWS, COLS);
  localparam int c_col_w  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_cnt_w  = $clog2(kp_max4(SCAN_DIV, DEBOUNCE_CYC, REPEAT_DLY, REPEAT_RATE) + 1);
  localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max   = '1;
  localparam logic [COLS-1:0]    c_col_one   = COLS'(1);

  kp_state_t             r_state, w_next;
  logic [c_col_w-1:0]    r_col_idx;
  logic [c_cnt_w-1:0]    r_scan_cnt;
  logic [ROWS-1:0]       r_snap;
  logic [c_code_w-1:0]   r_code;
  logic                  r_valid, r_pressed, r_multi, r_overflow;

  logic w_scan_last, w_advance, w_latch, w_accept, w_release;
  logic w_clr, w_match, w_done, w_emit, w_hs;
  logic [c_code_w-1:0] w_code;

  assign w_scan_last = (r_scan_cnt == c_scan_last);

  kp_stable_cnt #(
    .CNT_W (c_cnt_w),
    .TERM  (DEBOUNCE_CYC - 1)
  ) u_stable (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .match (w_match),
    .done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= SCAN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    w_latch   = 1'b0;
    w_accept  = 1'b0;
    w_release = 1'b0;
    w_match   = 1'b0;
    w_clr     = 1'b1;
    case (r_state)
      SCAN: begin
        if (w_scan_last) begin
          if (row != '0) begin
            w_latch = 1'b1;
            w_next  = DEB_PRESS;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      DEB_PRESS: begin
        w_clr   = 1'b0;
        w_match = (row == r_snap);
        if (!w_match) begin
          w_next    = SCAN;
          w_advance = 1'b1;
        end else if (w_done) begin
          w_accept = 1'b1;
          w_next   = HELD;
        end
      end
      HELD: begin
        // Nonzero changes while held are deliberately ignored.
        if (row == '0) w_next = DEB_REL;
      end
      DEB_REL: begin
        w_clr   = 1'b0;
        w_match = (row == '0);
        if (!w_match) begin
          w_next = HELD;
        end else if (w_done) begin
          w_release = 1'b1;
          w_next    = SCAN;
          w_advance = 1'b1;
        end
      end
      default: w_next = SCAN;
    endcase
  end

  // Scan divider only runs in SCAN; restarts for every new column.
  always_ff @(posedge clk) begin
    if (rst || (r_state != SCAN) || w_scan_last) begin
      r_scan_cnt <= '0;
    end else if (r_scan_cnt != c_cnt_max) begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_idx <= '0;
    end else if (w_advance) begin
      r_col_idx <= (r_col_idx == c_col_w'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
    end
  end

  assign columns = c_col_one << r_col_idx;

  always_ff @(posedge clk) begin
    if (rst)          r_snap <= '0;
    else if (w_latch) r_snap <= row;
  end

  // Column and snapshot stay frozen from detect to release, so the code
  // is valid for both the press event and any repeats.
  assign w_code = c_code_w'(int'(r_col_idx) * ROWS + lowest_set_idx(32'(r_snap)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pressed <= 1'b0;
      r_multi   <= 1'b0;
    end else if (w_accept) begin
      r_pressed <= 1'b1;
      r_multi   <= |(r_snap & (r_snap - 1'b1));
    end else if (w_release) begin
      r_pressed <= 1'b0;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // r_rpt_cnt holds cycles elapsed since accept (or since the last repeat).
  logic [c_cnt_w-1:0] r_rpt_cnt;
  logic               r_rpt_phase;
  logic               w_rpt_hit;

  assign w_rpt_hit = (r_state == HELD) &&
                     (r_rpt_phase ? (r_rpt_cnt == c_cnt_w'(REPEAT_RATE))
                                  : (r_rpt_cnt == c_cnt_w'(REPEAT_DLY)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
    end else if (w_accept) begin
      r_rpt_cnt   <= c_cnt_w'(1);
      r_rpt_phase <= 1'b0;
    end else if (w_rpt_hit) begin
      r_rpt_cnt   <= c_cnt_w'(1);
      r_rpt_phase <= 1'b1;
    end else if (r_pressed && (r_rpt_cnt != c_cnt_max)) begin
      r_rpt_cnt <= r_rpt_cnt + 1'b1;
    end
  end

  assign w_emit = w_accept || w_rpt_hit;
`else
  assign w_emit = w_accept;
`endif

  assign w_hs = r_valid && kif.key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_emit) begin
      if (!r_valid || w_hs) begin
        r_code  <= w_code;
        r_valid <= 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign kif.key_code  = r_code;
  assign kif.key_valid = r_valid;
  assign pressed       = r_pressed;
  assign multi_key     = r_multi;
  assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed self-checking bench for keypad_scanner. A simple key
//            model drives row only while the strobed column matches the
//            pressed key's column.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] columns;
  logic       pressed, multi_key, overflow;

  int checks   = 0;
  int failures = 0;

  bit         kb_on   = 1'b0;
  int         kb_col  = 0;
  logic [3:0] kb_rows = 4'b0000;

  keypad_scanner_if #(.CODE_W(4)) kif ();

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8),
    .REPEAT_DLY(40), .REPEAT_RATE(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .columns   (columns),
    .kif       (kif),
    .pressed   (pressed),
    .multi_key (multi_key),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always_comb row = (kb_on && columns[kb_col]) ? kb_rows : 4'b0000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (kif.key_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_pressed(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (pressed === lvl) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic press(input int col, input logic [3:0] rows);
    kb_col  = col;
    kb_rows = rows;
    kb_on   = 1'b1;
  endtask

  task automatic release_and_wait(input string name);
    bit ok;
    kb_on = 1'b0;
    wait_pressed(1'b0, 100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_release: pressed=%b required 0 within 100 cycles", name, pressed);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset;
    logic [3:0] exp_cols [4];
    exp_cols[0] = 4'b0010; exp_cols[1] = 4'b0100;
    exp_cols[2] = 4'b1000; exp_cols[3] = 4'b0001;
    rst = 1'b1;
    kb_on = 1'b0;
    kif.key_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (columns !== 4'b0001) begin failures++; $display("FAIL reset_columns: got %b required 0001", columns); end
    checks++;
    if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", kif.key_valid); end
    checks++;
    if (kif.key_code !== 4'd0) begin failures++; $display("FAIL reset_code: got %0d required 0", kif.key_code); end
    checks++;
    if ({pressed, multi_key, overflow} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: pressed/multi/ovf got %b required 000", {pressed, multi_key, overflow});
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick();
      checks++;
      if (columns !== exp_cols[(k + 3) % 4]) begin
        failures++; $display("FAIL scan_hold_%0d: got %b required %b", k, columns, exp_cols[(k + 3) % 4]);
      end
      tick();
      checks++;
      if (columns !== exp_cols[k]) begin
        failures++; $display("FAIL scan_rotate_%0d: got %b required %b", k, columns, exp_cols[k]);
      end
    end
  endtask

  task automatic test_clean_press;
    bit ok;
    kif.key_ready = 1'b1;
    press(2, 4'b0010);
    wait_valid(200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL clean_valid: key_valid=0 required 1 within 200 cycles");
    end else begin
      checks++;
      if (kif.key_code !== 4'd9) begin failures++; $display("FAIL clean_code: got %0d required 9", kif.key_code); end
      checks++;
      if (pressed !== 1'b1) begin failures++; $display("FAIL clean_pressed: got %b required 1", pressed); end
      tick();
      checks++;
      if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL clean_pulse: key_valid got %b required 0", kif.key_valid); end
    end
    kb_on = 1'b0;
    repeat (7) tick();
    checks++;
    if (pressed !== 1'b1) begin failures++; $display("FAIL release_early: pressed got %b required 1", pressed); end
    repeat (3) tick();
    checks++;
    if (pressed !== 1'b0) begin failures++; $display("FAIL release_done: pressed got %b required 0", pressed); end
    checks++;
    if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL release_no_event: key_valid got %b required 0", kif.key_valid); end
    repeat (4) tick();
  endtask

  task automatic test_bounce;
    bit seen_v = 1'b0;
    bit seen_p = 1'b0;
    kb_col  = 0;
    kb_rows = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      kb_on = ((i / 3) % 2) == 0;
      tick();
      if (kif.key_valid) seen_v = 1'b1;
      if (pressed)       seen_p = 1'b1;
    end
    kb_on = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (kif.key_valid) seen_v = 1'b1;
      if (pressed)       seen_p = 1'b1;
    end
    checks++;
    if (seen_v) begin failures++; $display("FAIL bounce_valid: key_valid seen 1 required never"); end
    checks++;
    if (seen_p) begin failures++; $display("FAIL bounce_pressed: pressed seen 1 required never"); end
  endtask

  task automatic test_multi_row;
    bit ok;
    press(0, 4'b1010);
    wait_valid(200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL multi_valid: key_valid=0 required 1 within 200 cycles");
    end else begin
      checks++;
      if (kif.key_code !== 4'd1) begin failures++; $display("FAIL multi_code: got %0d required 1", kif.key_code); end
      checks++;
      if (multi_key !== 1'b1) begin failures++; $display("FAIL multi_flag: got %b required 1", multi_key); end
    end
    release_and_wait("multi");
  endtask

  task automatic test_backpressure;
    bit ok;
    kif.key_ready = 1'b0;
    press(1, 4'b0001);
    wait_valid(200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_first_valid: key_valid=0 required 1 within 200 cycles");
    end else begin
      checks++;
      if (kif.key_code !== 4'd4) begin failures++; $display("FAIL bp_first_code: got %0d required 4", kif.key_code); end
      checks++;
      if (multi_key !== 1'b0) begin failures++; $display("FAIL bp_multi_clear: got %b required 0", multi_key); end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL bp_no_ovf_yet: got %b required 0", overflow); end
    end
    release_and_wait("bp1");
    press(3, 4'b0100);
    wait_pressed(1'b1, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_second_press: pressed=0 required 1 within 200 cycles"); end
    tick();
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b required 1", overflow); end
    checks++;
    if ({kif.key_valid, kif.key_code} !== {1'b1, 4'd4}) begin
      failures++; $display("FAIL bp_held: valid/code got %b/%0d required 1/4", kif.key_valid, kif.key_code);
    end
    release_and_wait("bp2");
    kif.key_ready = 1'b1;
    checks++;
    if ({kif.key_valid, kif.key_code} !== {1'b1, 4'd4}) begin
      failures++; $display("FAIL bp_deliver: valid/code got %b/%0d required 1/4", kif.key_valid, kif.key_code);
    end
    tick();
    checks++;
    if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: key_valid got %b required 0", kif.key_valid); end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL bp_sticky: overflow got %b required 1", overflow); end
  endtask

  task automatic test_repeat;
    bit ok;
    int n = 0;
    int exp_off [4];
    int exp_n;
    exp_off[0] = 40; exp_off[1] = 60; exp_off[2] = 80; exp_off[3] = 100;
`ifdef KEYPAD_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 0;
`endif
    kif.key_ready = 1'b1;
    press(2, 4'b0001);
    wait_valid(200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rpt_first: key_valid=0 required 1 within 200 cycles");
    end else begin
      checks++;
      if (kif.key_code !== 4'd8) begin failures++; $display("FAIL rpt_first_code: got %0d required 8", kif.key_code); end
      for (int i = 1; i <= 100; i++) begin
        tick();
        if (kif.key_valid) begin
          checks++;
          if (n >= 4 || i != exp_off[n] || kif.key_code !== 4'd8) begin
            failures++;
            $display("FAIL rpt_event_%0d: offset %0d code %0d required offset %0d code 8",
                     n, i, kif.key_code, (n < 4) ? exp_off[n] : -1);
          end
          n++;
        end
      end
      checks++;
      if (n != exp_n) begin failures++; $display("FAIL rpt_count: got %0d repeats required %0d", n, exp_n); end
    end
    release_and_wait("rpt");
  endtask

  task automatic test_midop_reset;
    bit ok;
    kif.key_ready = 1'b0;
    press(1, 4'b0010);
    wait_valid(200, ok);
    checks++;
    if (!ok || pressed !== 1'b1 || kif.key_code !== 4'd5) begin
      failures++; $display("FAIL midrst_setup: valid/pressed/code got %b/%b/%0d required 1/1/5",
                           kif.key_valid, pressed, kif.key_code);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (columns !== 4'b0001) begin failures++; $display("FAIL midrst_columns: got %b required 0001", columns); end
    checks++;
    if ({kif.key_valid, kif.key_code} !== 5'b0) begin
      failures++; $display("FAIL midrst_out: valid/code got %b/%0d required 0/0", kif.key_valid, kif.key_code);
    end
    checks++;
    if ({pressed, multi_key, overflow} !== 3'b000) begin
      failures++; $display("FAIL midrst_flags: pressed/multi/ovf got %b required 000", {pressed, multi_key, overflow});
    end
    kb_on = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    kif.key_ready = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_row();
    test_backpressure();
    test_repeat();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
